// File: rtl/fft_bank_rd_ctrl.sv
// fft_bank_rd_ctrl: credit-based read sequencer for the eight FFT data banks,
// realigning bank data through a show-ahead group FIFO toward the reindex mux.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
module fft_bank_rd_ctrl #(
   parameter int DATA_W     = `DATA_WIDTH,
   parameter int ADDR_W     = 8,
   parameter int MEM_LAT    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        point,
   input  logic              point_2_mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] grp_num,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        bank_rd_en,
   output logic [ADDR_W-1:0] bank_addr,
   input  logic [DATA_W-1:0] bank_rdata_0,
   input  logic [DATA_W-1:0] bank_rdata_1,
   input  logic [DATA_W-1:0] bank_rdata_2,
   input  logic [DATA_W-1:0] bank_rdata_3,
   input  logic [DATA_W-1:0] bank_rdata_4,
   input  logic [DATA_W-1:0] bank_rdata_5,
   input  logic [DATA_W-1:0] bank_rdata_6,
   input  logic [DATA_W-1:0] bank_rdata_7,
   output logic [DATA_W-1:0] mem_OUT_0,
   output logic [DATA_W-1:0] mem_OUT_1,
   output logic [DATA_W-1:0] mem_OUT_2,
   output logic [DATA_W-1:0] mem_OUT_3,
   output logic [DATA_W-1:0] mem_OUT_4,
   output logic [DATA_W-1:0] mem_OUT_5,
   output logic [DATA_W-1:0] mem_OUT_6,
   output logic [DATA_W-1:0] mem_OUT_7,
   output logic              out_valid,
   input  logic              out_ready
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t             r_state;
   logic [7:0]         r_mask;
   logic [ADDR_W-1:0]  r_cnt;
   logic [ADDR_W-1:0]  r_rem;
   logic [ADDR_W-1:0]  r_addr;
   logic [7:0]         r_rd_en;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
   logic [MEM_LAT-1:0] r_pipe;
   logic [DATA_W-1:0]  r_mem [FIFO_DEPTH][8];
   logic [PW-1:0]      r_wp;
   logic [PW-1:0]      r_rp;
   logic [CW-1:0]      r_count;

   logic [DATA_W-1:0]  w_rdata [8];
   logic [7:0]         w_mask;
   logic               w_legal;
   logic               w_wr;
   logic               w_pop;
   logic               w_issue;
   logic [MEM_LAT-1:0] w_pipe_nxt;
   logic [CW-1:0]      w_count_nxt;
   int                 w_occ;

   assign w_rdata[0] = bank_rdata_0;
   assign w_rdata[1] = bank_rdata_1;
   assign w_rdata[2] = bank_rdata_2;
   assign w_rdata[3] = bank_rdata_3;
   assign w_rdata[4] = bank_rdata_4;
   assign w_rdata[5] = bank_rdata_5;
   assign w_rdata[6] = bank_rdata_6;
   assign w_rdata[7] = bank_rdata_7;

   always_comb begin
      w_legal = 1'b1;
      w_mask  = 8'h00;
      case (point)
         3'd7:    w_mask = 8'h7F;
         3'd5:    w_mask = 8'h1F;
         3'd4:    w_mask = 8'h0F;
         3'd3:    w_mask = 8'h3F;
         3'd2:    w_mask = point_2_mode ? 8'hFF : 8'h3F;
         default: w_legal = 1'b0;
      endcase
   end

   assign w_wr        = r_pipe[MEM_LAT-1];
   assign w_pop       = (r_count != '0) && out_ready;
   assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);

   always_comb begin
      w_pipe_nxt    = '0;
      w_pipe_nxt[0] = |r_rd_en;
      for (int i = 1; i < MEM_LAT; i++) w_pipe_nxt[i] = r_pipe[i-1];
   end

   // Decision is made one cycle ahead, so the read issued this cycle
   // already holds a credit; a same-cycle pop is not counted back.
   always_comb begin
      w_occ = 32'(r_count) + 32'(|r_rd_en);
      for (int i = 0; i < MEM_LAT; i++) w_occ = w_occ + 32'(r_pipe[i]);
   end

   assign w_issue = w_occ < FIFO_DEPTH;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_mask  <= '0;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_addr  <= '0;
         r_rd_en <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_rd_en <= 8'h00;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (!w_legal) begin
                     r_err <= 1'b1;
                  end else if (grp_num == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_mask  <= w_mask;
                     r_rd_en <= w_mask;
                     r_addr  <= base_addr;
                     r_cnt   <= base_addr + ADDR_W'(1);
                     r_rem   <= grp_num - ADDR_W'(1);
                     r_busy  <= 1'b1;
                     r_state <= (grp_num == ADDR_W'(1)) ? S_DRAIN : S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (w_issue) begin
                  r_rd_en <= r_mask;
                  r_addr  <= r_cnt;
                  r_cnt   <= r_cnt + ADDR_W'(1);
                  r_rem   <= r_rem - ADDR_W'(1);
                  if (r_rem == ADDR_W'(1)) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_pipe_nxt == '0 && w_count_nxt == '0) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe  <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         for (int e = 0; e < FIFO_DEPTH; e++)
            for (int l = 0; l < 8; l++) r_mem[e][l] <= '0;
      end else begin
         r_pipe  <= w_pipe_nxt;
         r_count <= w_count_nxt;
         if (w_wr) begin
            for (int l = 0; l < 8; l++)
               r_mem[r_wp][l] <= r_mask[l] ? w_rdata[l] : '0;
            r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + PW'(1);
         end
         if (w_pop)
            r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + PW'(1);
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign bank_rd_en = r_rd_en;
   assign bank_addr  = r_addr;
   assign out_valid  = r_count != '0;
   assign mem_OUT_0  = r_mem[r_rp][0];
   assign mem_OUT_1  = r_mem[r_rp][1];
   assign mem_OUT_2  = r_mem[r_rp][2];
   assign mem_OUT_3  = r_mem[r_rp][3];
   assign mem_OUT_4  = r_mem[r_rp][4];
   assign mem_OUT_5  = r_mem[r_rp][5];
   assign mem_OUT_6  = r_mem[r_rp][6];
   assign mem_OUT_7  = r_mem[r_rp][7];

endmodule

// File: tb/tb_fft_bank_rd_ctrl.sv
// tb_fft_bank_rd_ctrl: randomized bench checking the bank read sequencer
// against a group-level model of addresses, lane masks and delivered data.
`timescale 1ns/1ps
module tb_fft_bank_rd_ctrl;
   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [2:0]    point;
   logic          point_2_mode;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] grp_num;
   logic          busy, done, err;
   logic [7:0]    bank_rd_en;
   logic [AW-1:0] bank_addr;
   logic [DW-1:0] rdata [8];
   logic [DW-1:0] mout [8];
   logic          out_valid;
   logic          out_ready;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;
   logic [31:0] seed = 32'h1234;

   int            iss_cyc [$];
   logic [7:0]    iss_en [$];
   logic [AW-1:0] iss_addr [$];
   int            beat_cyc [$];
   logic [8*DW-1:0] beat_dat [$];
   logic [8*DW-1:0] exp_dat [$];
   int done_cyc [$];
   int err_cyc [$];
   int busy_n, issued_n, popped_n, max_out, hold_viol;
   bit hold_chk;
   logic [8*DW-1:0] prev_lanes, cur;

   fft_bank_rd_ctrl #(
      .DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .point(point),
      .point_2_mode(point_2_mode), .base_addr(base_addr),
      .grp_num(grp_num), .busy(busy), .done(done), .err(err),
      .bank_rd_en(bank_rd_en), .bank_addr(bank_addr),
      .bank_rdata_0(rdata[0]), .bank_rdata_1(rdata[1]),
      .bank_rdata_2(rdata[2]), .bank_rdata_3(rdata[3]),
      .bank_rdata_4(rdata[4]), .bank_rdata_5(rdata[5]),
      .bank_rdata_6(rdata[6]), .bank_rdata_7(rdata[7]),
      .mem_OUT_0(mout[0]), .mem_OUT_1(mout[1]),
      .mem_OUT_2(mout[2]), .mem_OUT_3(mout[3]),
      .mem_OUT_4(mout[4]), .mem_OUT_5(mout[5]),
      .mem_OUT_6(mout[6]), .mem_OUT_7(mout[7]),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] val(int b, logic [AW-1:0] a);
      return DW'(seed + 32'(b) * 32'h1111 + 32'(a) * 32'h0203 + 32'd1);
   endfunction

   function automatic logic [7:0] emask(int p, bit m);
      case (p)
         7: return 8'h7F;
         5: return 8'h1F;
         4: return 8'h0F;
         3: return 8'h3F;
         2: return m ? 8'hFF : 8'h3F;
         default: return 8'h00;
      endcase
   endfunction

   // Bank memories: one-cycle read latency, garbage on unread lanes.
   always @(posedge clk)
      for (int b = 0; b < 8; b++)
         rdata[b] <= bank_rd_en[b] ? val(b, bank_addr) : DW'($urandom);

   always @(negedge clk) begin
      for (int b = 0; b < 8; b++) cur[b*DW +: DW] = mout[b];
      if (|bank_rd_en) begin
         iss_cyc.push_back(cyc);
         iss_en.push_back(bank_rd_en);
         iss_addr.push_back(bank_addr);
         if (issued_n - popped_n > max_out) max_out = issued_n - popped_n;
         issued_n++;
      end
      if (hold_chk && (!out_valid || cur !== prev_lanes)) hold_viol++;
      hold_chk   = out_valid && !out_ready;
      prev_lanes = cur;
      if (out_valid && out_ready) begin
         beat_cyc.push_back(cyc);
         beat_dat.push_back(cur);
         popped_n++;
      end
      if (done) done_cyc.push_back(cyc);
      if (err) err_cyc.push_back(cyc);
      if (busy) busy_n++;
   end

   task automatic clr();
      iss_cyc.delete(); iss_en.delete(); iss_addr.delete();
      beat_cyc.delete(); beat_dat.delete();
      done_cyc.delete(); err_cyc.delete();
      busy_n = 0; issued_n = 0; popped_n = 0; max_out = 0;
      hold_viol = 0; hold_chk = 0;
   endtask

   task automatic mk_exp(logic [7:0] m, logic [AW-1:0] b, int n);
      logic [8*DW-1:0] g;
      logic [AW-1:0] a;
      exp_dat.delete();
      for (int i = 0; i < n; i++) begin
         a = AW'(32'(b) + i);
         for (int l = 0; l < 8; l++) g[l*DW +: DW] = m[l] ? val(l, a) : '0;
         exp_dat.push_back(g);
      end
   endtask

   task automatic cmd(int p, bit m, logic [AW-1:0] b, int n);
      clr();
      @(posedge clk); #1;
      start = 1'b1; point = 3'(p); point_2_mode = m;
      base_addr = b; grp_num = AW'(n);
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (done_cyc.size() > 0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; point = 3'd0; point_2_mode = 1'b0;
      base_addr = '0; grp_num = '0; out_ready = 1'b1;
      clr();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, done, err, bank_rd_en, bank_addr, out_valid} !== '0) begin
         bad++;
         $display("FAIL reset_ctrl: got %0h want 0",
                  {busy, done, err, bank_rd_en, bank_addr, out_valid});
      end
      for (int b = 0; b < 8; b++) cur[b*DW +: DW] = mout[b];
      total++;
      if (cur !== '0) begin
         bad++;
         $display("FAIL reset_lanes: got %0h want 0", cur);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      bit ok;
      int nb;
      seed = $urandom;
      cmd(7, 0, 8'h10, 3);
      wait_done(60, ok);
      mk_exp(8'h7F, 8'h10, 3);
      total++;
      if (!ok) begin bad++; $display("FAIL basic_done_timeout: got 0 want 1"); end
      nb = 0;
      for (int i = 0; i < 3; i++)
         if (i >= iss_cyc.size() || iss_cyc[i] - t0 != i + 1 ||
             iss_en[i] !== 8'h7F || iss_addr[i] !== AW'(8'h10 + i)) nb++;
      total++;
      if (nb != 0 || iss_cyc.size() != 3) begin
         bad++;
         $display("FAIL basic_issue: got %0d reads %0d wrong want 3 0", iss_cyc.size(), nb);
      end
      nb = 0;
      for (int i = 0; i < 3; i++)
         if (i >= beat_cyc.size() || beat_cyc[i] - t0 != i + 3 ||
             beat_dat[i] !== exp_dat[i]) nb++;
      total++;
      if (nb != 0 || beat_dat.size() != 3) begin
         bad++;
         $display("FAIL basic_beats: got %0d beats %0d wrong want 3 0", beat_dat.size(), nb);
      end
      total++;
      if (done_cyc.size() != 1 || done_cyc[0] - t0 != 6) begin
         bad++;
         $display("FAIL basic_done_cycle: got %0d want 6",
                  done_cyc.size() > 0 ? done_cyc[0] - t0 : -1);
      end
   endtask

   task automatic test_point2();
      bit ok;
      int nb;
      logic [AW-1:0] b;
      for (int m = 0; m < 2; m++) begin
         seed = $urandom; b = AW'($urandom);
         cmd(2, m[0], b, 2);
         wait_done(60, ok);
         mk_exp(emask(2, m[0]), b, 2);
         nb = 0;
         foreach (iss_en[i]) if (iss_en[i] !== emask(2, m[0])) nb++;
         total++;
         if (!ok || nb != 0 || iss_en.size() != 2) begin
            bad++;
            $display("FAIL p2_issue_mode%0d: got %0d reads %0d bad mask want 2 0",
                     m, iss_en.size(), nb);
         end
         nb = 0;
         foreach (exp_dat[i]) if (i >= beat_dat.size() || beat_dat[i] !== exp_dat[i]) nb++;
         total++;
         if (nb != 0 || beat_dat.size() != 2) begin
            bad++;
            $display("FAIL p2_beats_mode%0d: got %0d beats %0d wrong want 2 0",
                     m, beat_dat.size(), nb);
         end
      end
   endtask

   task automatic test_stall();
      bit ok;
      int nb;
      logic [AW-1:0] b;
      seed = $urandom; b = AW'($urandom);
      out_ready = 1'b1;
      cmd(5, 0, b, 10);
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      total++;
      if (iss_cyc.size() != DEPTH || beat_dat.size() != 0 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL stall_credit: got %0d reads %0d beats valid %0b want %0d 0 1",
                  iss_cyc.size(), beat_dat.size(), out_valid, DEPTH);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_done(100, ok);
      mk_exp(8'h1F, b, 10);
      nb = 0;
      foreach (exp_dat[i]) if (i >= beat_dat.size() || beat_dat[i] !== exp_dat[i]) nb++;
      total++;
      if (!ok || nb != 0 || beat_dat.size() != 10) begin
         bad++;
         $display("FAIL stall_beats: got %0d beats %0d wrong want 10 0", beat_dat.size(), nb);
      end
      total++;
      if (hold_viol != 0) begin
         bad++;
         $display("FAIL stall_hold: got %0d changes want 0", hold_viol);
      end
      total++;
      if (max_out > DEPTH - 1) begin
         bad++;
         $display("FAIL stall_outstanding: got %0d want <= %0d", max_out, DEPTH - 1);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      int nb;
      logic [AW-1:0] want [4];
      want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
      seed = $urandom;
      cmd(4, 0, 8'hFE, 4);
      wait_done(60, ok);
      mk_exp(8'h0F, 8'hFE, 4);
      nb = 0;
      for (int i = 0; i < 4; i++)
         if (i >= iss_addr.size() || iss_addr[i] !== want[i]) nb++;
      total++;
      if (!ok || nb != 0 || iss_addr.size() != 4) begin
         bad++;
         $display("FAIL wrap_addr: got %0d reads %0d wrong want 4 0", iss_addr.size(), nb);
      end
      nb = 0;
      foreach (exp_dat[i]) if (i >= beat_dat.size() || beat_dat[i] !== exp_dat[i]) nb++;
      total++;
      if (nb != 0 || beat_dat.size() != 4) begin
         bad++;
         $display("FAIL wrap_beats: got %0d beats %0d wrong want 4 0", beat_dat.size(), nb);
      end
   endtask

   task automatic test_err_zero();
      cmd(6, 0, 8'h20, 5);
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (err_cyc.size() != 1 || err_cyc[0] - t0 != 1) begin
         bad++;
         $display("FAIL err_pulse: got %0d pulses want 1 at cycle 1", err_cyc.size());
      end
      total++;
      if (iss_cyc.size() != 0 || busy_n != 0 || done_cyc.size() != 0) begin
         bad++;
         $display("FAIL err_side: got reads %0d busy %0d done %0d want 0 0 0",
                  iss_cyc.size(), busy_n, done_cyc.size());
      end
      cmd(4, 0, 8'h30, 0);
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (done_cyc.size() != 1 || done_cyc[0] - t0 != 1) begin
         bad++;
         $display("FAIL zero_done: got %0d pulses want 1 at cycle 1", done_cyc.size());
      end
      total++;
      if (iss_cyc.size() != 0 || busy_n != 0 || err_cyc.size() != 0) begin
         bad++;
         $display("FAIL zero_side: got reads %0d busy %0d err %0d want 0 0 0",
                  iss_cyc.size(), busy_n, err_cyc.size());
      end
   endtask

   task automatic test_random();
      int pts [5] = '{2, 3, 4, 5, 7};
      int p, n, nb;
      bit m;
      logic [AW-1:0] b;
      for (int k = 0; k < 6; k++) begin
         seed = $urandom;
         p = pts[$urandom_range(0, 4)];
         m = 1'($urandom);
         b = AW'($urandom);
         n = $urandom_range(1, 12);
         cmd(p, m, b, n);
         for (int c = 0; c < 400 && done_cyc.size() == 0; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 2) != 0);
         end
         out_ready = 1'b1;
         mk_exp(emask(p, m), b, n);
         nb = 0;
         foreach (exp_dat[i]) if (i >= beat_dat.size() || beat_dat[i] !== exp_dat[i]) nb++;
         total++;
         if (done_cyc.size() != 1 || nb != 0 || beat_dat.size() != n) begin
            bad++;
            $display("FAIL rand%0d_beats: got %0d beats %0d wrong done %0d want %0d 0 1",
                     k, beat_dat.size(), nb, done_cyc.size(), n);
         end
         total++;
         if (hold_viol != 0 || max_out > DEPTH - 1 || iss_cyc.size() != n) begin
            bad++;
            $display("FAIL rand%0d_flow: got hold %0d out %0d reads %0d want 0 <=%0d %0d",
                     k, hold_viol, max_out, iss_cyc.size(), DEPTH - 1, n);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int nb;
      logic [AW-1:0] b;
      seed = $urandom;
      out_ready = 1'b0;
      cmd(3, 0, AW'($urandom), 8);
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL midrst_pre: got valid %0b busy %0b want 1 1", out_valid, busy);
      end
      rst_n = 1'b0;
      #1;
      for (int l = 0; l < 8; l++) cur[l*DW +: DW] = mout[l];
      total++;
      if ({busy, done, err, bank_rd_en, bank_addr, out_valid} !== '0 || cur !== '0) begin
         bad++;
         $display("FAIL midrst_outputs: got %0h lanes %0h want 0 0",
                  {busy, done, err, bank_rd_en, bank_addr, out_valid}, cur);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      seed = $urandom; b = AW'($urandom);
      cmd(7, 0, b, 3);
      wait_done(60, ok);
      mk_exp(8'h7F, b, 3);
      nb = 0;
      foreach (exp_dat[i]) if (i >= beat_dat.size() || beat_dat[i] !== exp_dat[i]) nb++;
      total++;
      if (!ok || nb != 0 || beat_dat.size() != 3) begin
         bad++;
         $display("FAIL midrst_new: got %0d beats %0d wrong want 3 0", beat_dat.size(), nb);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_point2();
      test_stall();
      test_wrap();
      test_err_zero();
      test_random();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
